// File: rtl/fpu_sp_pkg.sv
// fpu_sp_pkg: shared constants and state encoding for the FP adder request controller
package fpu_sp_pkg;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int ENT_W = 33;
  localparam int FLAG_BIT = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} req_state_t;
endpackage

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: small result queue with push/pop, occupancy count and head read from storage flops
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= push_data;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fpu_sp_req_ctrl.sv
// fpu_sp_req_ctrl: issues operand pairs to the FP adder core one at a time, queues results, watchdogs a hung core
module fpu_sp_req_ctrl
  import fpu_sp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] fpu_din1,
  output logic [31:0] fpu_din2,
  output logic        fpu_dval,
  input  logic [31:0] fpu_result,
  input  logic        fpu_rdy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_tmo,
  output logic        busy,
  output logic        err_tmo,
  output logic        err_spur,
  input  logic        err_clr
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  req_state_t state, state_nxt;
  logic [TW-1:0] wdog;
  logic [CW-1:0] count;
  logic [ENT_W-1:0] head;
  logic accept, wait_done, wait_tmo, spur;
  assign in_ready = rst_n && state == IDLE && count < CW'(DEPTH);
  assign accept = in_valid && in_ready;
  assign fpu_dval = state == ISSUE;
  assign wait_done = state == WAIT && fpu_rdy;
  assign wait_tmo = state == WAIT && !fpu_rdy && wdog == TW'(TIMEOUT - 1);
  assign spur = fpu_rdy && (state == IDLE || state == ISSUE);
  assign busy = state != IDLE || out_valid;
  assign out_data = head[31:0];
  assign out_tmo = head[FLAG_BIT];
  fpu_result_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wait_done || wait_tmo),
    .push_data ({wait_tmo, wait_tmo ? FP_QNAN : fpu_result}),
    .pop       (out_ready),
    .head      (head),
    .valid     (out_valid),
    .count     (count)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = accept ? ISSUE : IDLE;
      ISSUE: state_nxt = WAIT;
      WAIT:  state_nxt = fpu_rdy ? IDLE : wait_tmo ? DRAIN : WAIT;
      DRAIN: state_nxt = fpu_rdy || err_clr ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // a late rdy after a timeout belongs to the abandoned op, so DRAIN swallows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_din1 <= '0;
      fpu_din2 <= '0;
      wdog <= '0;
      err_tmo <= 1'b0;
      err_spur <= 1'b0;
    end else begin
      fpu_din1 <= accept ? in_a : fpu_din1;
      fpu_din2 <= accept ? in_b : fpu_din2;
      wdog <= state == ISSUE ? '0 : state == WAIT ? wdog + 1'b1 : wdog;
      err_tmo <= wait_tmo || (err_tmo && !err_clr);
      err_spur <= spur || (err_spur && !err_clr);
    end
  end
endmodule

// File: tb/tb_fpu_sp_req_ctrl.sv
// tb_fpu_sp_req_ctrl: directed checks of the FP request controller against a behavioural core
module tb_fpu_sp_req_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0, fpu_din1, fpu_din2, fpu_result, out_data;
  logic fpu_dval, fpu_rdy, out_valid, out_tmo, busy, err_tmo, err_spur;
  logic out_ready = 1'b0, err_clr = 1'b0;
  logic core_rdy = 1'b0, man_rdy = 1'b0, core_on = 1'b1, mon_en = 1'b0;
  logic [31:0] core_res = '0, man_res = '0;
  int core_delay = 3, dval_cnt = 0, n_cmp = 0, n_err = 0, d0;
  logic [32:0] got_q[$];

  assign fpu_rdy = core_rdy || man_rdy;
  assign fpu_result = man_rdy ? man_res : core_res;

  fpu_sp_req_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_dval(fpu_dval), .fpu_result(fpu_result),
    .fpu_rdy(fpu_rdy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tmo(out_tmo), .busy(busy), .err_tmo(err_tmo), .err_spur(err_spur), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fpu_dval) dval_cnt++;
    if (mon_en && out_valid && out_ready) got_q.push_back({out_tmo, out_data});
  end

  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h7F80_0000 && b == 32'hFF80_0000) return 32'h7FC0_0000;
    return a + b;
  endfunction

  initial begin
    logic [31:0] a, b;
    forever begin
      @(posedge clk); #1;
      if (fpu_dval && core_on) begin
        a = fpu_din1;
        b = fpu_din2;
        repeat (core_delay) @(posedge clk);
        #1 core_rdy = 1'b1;
        core_res = core_fn(a, b);
        @(posedge clk); #1 core_rdy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 30) begin tick(); n++; end
    check({tag, "_acc"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [32:0] exp);
    int n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    check({tag, "_v"}, out_valid, 1);
    check(tag, {out_tmo, out_data}, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic rdy_pulse(input logic [31:0] r);
    man_rdy = 1'b1; man_res = r;
    tick();
    man_rdy = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_dval", fpu_dval, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_tmo, err_spur, out_tmo}, 0);
    check("rst_data", {out_data, fpu_din1}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // single add, latency accept->dval and rdy->out_valid
    d0 = dval_cnt;
    send("t1", 32'h3F80_0000, 32'h4000_0000);
    check("t1_dval", fpu_dval, 1);
    check("t1_din", {fpu_din1, fpu_din2}, {32'h3F80_0000, 32'h4000_0000});
    tick();
    check("t1_dval_once", fpu_dval, 0);
    repeat (2) tick();
    check("t1_wait_ready", in_ready, 0);
    check("t1_no_early", out_valid, 0);
    tick();
    check("t1_out_valid", out_valid, 1);
    check("t1_dval_cnt", dval_cnt - d0, 1);
    check("t1_errs", {err_tmo, err_spur}, 0);
    pop_expect("t1_data", {1'b0, 32'h4040_0000});
    check("t1_empty_busy", busy, 0);

    // fill FIFO, backpressure, then release one slot
    core_delay = 5;
    for (int i = 1; i <= 4; i++) send("t2", 32'(i), 32'h100);
    repeat (8) tick();
    check("t2_full_ready", in_ready, 0);
    check("t2_busy", busy, 1);
    d0 = dval_cnt;
    in_valid = 1'b1; in_a = 32'h5; in_b = 32'h100;
    repeat (3) tick();
    check("t2_blocked", dval_cnt - d0, 0);
    check("t2_head", {out_tmo, out_data}, {1'b0, 32'h101});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_slot_ready", in_ready, 1);
    send("t2_5th", 32'h5, 32'h100);
    pop_expect("t2_q102", {1'b0, 32'h102});
    pop_expect("t2_q103", {1'b0, 32'h103});
    pop_expect("t2_q104", {1'b0, 32'h104});
    pop_expect("t2_q105", {1'b0, 32'h105});

    // hung core -> watchdog entry, DRAIN until late rdy
    core_on = 1'b0;
    send("t3", 32'h1234, 32'h5678);
    repeat (16) tick();
    check("t3_not_yet", out_valid, 0);
    check("t3_no_err_yet", err_tmo, 0);
    tick();
    check("t3_valid", out_valid, 1);
    check("t3_entry", {out_tmo, out_data}, {1'b1, 32'h7FC0_0000});
    check("t3_err_tmo", err_tmo, 1);
    repeat (3) tick();
    check("t3_drain_ready", in_ready, 0);
    rdy_pulse(32'hDEAD_BEEF);
    check("t3_idle_ready", in_ready, 1);
    check("t3_no_spur", err_spur, 0);
    pop_expect("t3_only_tmo", {1'b1, 32'h7FC0_0000});
    check("t3_discarded", out_valid, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_clr", err_tmo, 0);

    // spurious rdy in IDLE
    rdy_pulse(32'h1111_1111);
    check("t4_spur", err_spur, 1);
    check("t4_no_push", out_valid, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr", err_spur, 0);
    err_clr = 1'b1;
    rdy_pulse(32'h2222_2222);
    err_clr = 1'b0;
    check("t4_set_wins", err_spur, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // continuous stream, consumer always ready
    core_on = 1'b1; core_delay = 2;
    out_ready = 1'b1; mon_en = 1'b1;
    send("t5a", 32'h7F80_0000, 32'hFF80_0000);
    send("t5b", 32'h3F80_0000, 32'h4000_0000);
    send("t5c", 32'h5, 32'h6);
    repeat (6) tick();
    mon_en = 1'b0; out_ready = 1'b0;
    check("t5_cnt", got_q.size(), 3);
    check("t5_r0", got_q.size() > 0 ? got_q[0] : 33'h0, {1'b0, 32'h7FC0_0000});
    check("t5_r1", got_q.size() > 1 ? got_q[1] : 33'h0, {1'b0, 32'h4040_0000});
    check("t5_r2", got_q.size() > 2 ? got_q[2] : 33'h0, {1'b0, 32'h0000_000B});
    check("t5_idle", {busy, err_tmo, err_spur}, 0);

    // reset during WAIT with two entries queued
    core_delay = 8;
    send("t6a", 32'h1, 32'h2);
    send("t6b", 32'h3, 32'h4);
    send("t6c", 32'h5, 32'h6);
    repeat (2) tick();
    check("t6_pre_busy", busy, 1);
    check("t6_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_valid", {out_valid, fpu_dval, busy}, 0);
    check("t6_rst_data", {out_tmo, out_data, fpu_din1, fpu_din2}, 0);
    check("t6_rst_errs", {err_tmo, err_spur}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_post_ready", in_ready, 1);
    check("t6_post_empty", {out_valid, busy}, 0);
    repeat (10) tick();
    check("t6_late_spur", err_spur, 1);
    check("t6_late_no_push", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
